// File: rtl/regfile_pkg.sv
// Shared defaults and clear-FSM state type for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: stored-value mux with same-cycle write forwarding and pending lookup.
module regfile_rdport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]        raddr,
    input  logic                 blank,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [XLEN-1:0]      wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd1,
    input  logic [NREG*XLEN-1:0] reg_flat,
    input  logic [NREG-1:0]      pending,
    output logic [XLEN-1:0]      rdata,
    output logic                 rpend
);

    logic [XLEN-1:0] stored;
    logic            hit0;
    logic            hit1;

    always_comb begin
        stored = '0;
        for (int r = 0; r < NREG; r++) begin
            if (raddr == AW'(r)) begin
                stored = reg_flat[r*XLEN +: XLEN];
            end
        end
    end

    assign hit0 = we0 && (wa0 == raddr);
    assign hit1 = we1 && (wa1 == raddr);

    // Port 1 beats port 0 so forwarding agrees with what the array will hold after the edge.
    always_comb begin
        rdata = '0;
        rpend = 1'b0;
        if (!blank && raddr != '0) begin
            if (hit1) begin
                rdata = wd1;
            end else if (hit0) begin
                rdata = wd0;
            end else begin
                rdata = stored;
            end
            rpend = pending[raddr] && !hit0 && !hit1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRD-read register file with pending-bit scoreboard and a sequential bulk clear.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [XLEN-1:0]      wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd1,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rpend,
    input  logic                 clr_start,
    output logic                 clr_busy
);

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    clr_state_t      state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;
    logic [NREG*XLEN-1:0] reg_flat;
    logic            wr0;
    logic            wr1;
    logic            read_blank;

    assign wr0        = we0 && (wa0 != '0) && !clr_busy;
    assign wr1        = we1 && (wa1 != '0) && !clr_busy;
    assign read_blank = clr_busy || !rst;

    // Terminal test compares against the last index so the counter never has to wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_cnt  <= AW'(1);
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_REG) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_cnt  <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (clr_busy) begin
            regs[clr_cnt] <= '0;
        end else begin
            if (wr0) begin
                regs[wa0] <= wd0;
            end
            if (wr1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // A new issue (sb_set) overrides the completion of an older producer to the same register.
    always_comb begin
        pending_next = pending;
        if (!clr_busy) begin
            if (clr_start) begin
                pending_next = '0;
            end else begin
                if (wr0) begin
                    pending_next[wa0] = 1'b0;
                end
                if (wr1) begin
                    pending_next[wa1] = 1'b0;
                end
                if (sb_set && sb_addr != '0) begin
                    pending_next[sb_addr] = 1'b1;
                end
            end
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_flat
        assign reg_flat[r*XLEN +: XLEN] = regs[r];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rdport
        regfile_rdport #(
            .XLEN(XLEN),
            .NREG(NREG),
            .AW  (AW)
        ) u_rdport (
            .raddr   (raddr[p*AW +: AW]),
            .blank   (read_blank),
            .we0     (we0),
            .wa0     (wa0),
            .wd0     (wd0),
            .we1     (we1),
            .wa1     (wa1),
            .wd1     (wd1),
            .reg_flat(reg_flat),
            .pending (pending),
            .rdata   (rdata[p*XLEN +: XLEN]),
            .rpend   (rpend[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic against an array model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rpend;
    logic                clr_start;
    logic                clr_busy;

    logic [XLEN-1:0] ref_mem [NREG];
    bit              ref_pend [NREG];
    int              busy_left;
    int              check_cnt;
    int              pass_cnt;

    regfile_sb #(
        .XLEN(XLEN),
        .NREG(NREG),
        .NRD (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .raddr    (raddr),
        .rdata    (rdata),
        .rpend    (rpend),
        .clr_start(clr_start),
        .clr_busy (clr_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [XLEN-1:0] expRdata(input logic [AW-1:0] ra);
        if (!rst || busy_left > 0 || ra == 0) return '0;
        if (we1 && wa1 == ra) return wd1;
        if (we0 && wa0 == ra) return wd0;
        return ref_mem[ra];
    endfunction

    function automatic logic expRpend(input logic [AW-1:0] ra);
        if (!rst || ra == 0) return 1'b0;
        if ((we1 && wa1 == ra) || (we0 && wa0 == ra)) return 1'b0;
        return ref_pend[ra];
    endfunction

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                                 input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                                 input logic s, input logic [AW-1:0] sa,
                                 input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        sb_set = s; sb_addr = sa;
        raddr = {r1, r0};
    endtask

    // Reference behaviour at a clock edge; a started clear is modelled as zeroing everything at once.
    task automatic modelEdge();
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                ref_mem[r] = '0;
                ref_pend[r] = 1'b0;
            end
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (we0 && wa0 != 0) ref_mem[wa0] = wd0;
            if (we1 && wa1 != 0) ref_mem[wa1] = wd1;
            if (clr_start) begin
                for (int r = 0; r < NREG; r++) begin
                    ref_mem[r] = '0;
                    ref_pend[r] = 1'b0;
                end
                busy_left = NREG - 1;
            end else begin
                if (we0 && wa0 != 0) ref_pend[wa0] = 1'b0;
                if (we1 && wa1 != 0) ref_pend[wa1] = 1'b0;
                if (sb_set && sb_addr != 0) ref_pend[sb_addr] = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag);
        #3;
        checkOutput($sformatf("%s.busy", tag), XLEN'(clr_busy), XLEN'(busy_left > 0));
        for (int p = 0; p < NRD; p++) begin
            checkOutput($sformatf("%s.rdata%0d", tag, p), rdata[p*XLEN +: XLEN], expRdata(raddr[p*AW +: AW]));
            checkOutput($sformatf("%s.rpend%0d", tag, p), XLEN'(rpend[p]), XLEN'(expRpend(raddr[p*AW +: AW])));
        end
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic readAll(input string tag);
        for (int k = 0; k < NREG / 2; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, AW'(2 * k), AW'(2 * k + 1));
            step($sformatf("%s[%0d]", tag, k));
        end
    endtask

    task automatic fillAll();
        for (int r = 1; r < NREG; r++) begin
            applyStimulus(1, AW'(r), ($urandom | 32'h1), 0, 0, 0, 0, 0, 0, 0);
            step($sformatf("fill%0d", r));
        end
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        busy_left = 0;
        for (int r = 0; r < NREG; r++) begin
            ref_mem[r] = '0;
            ref_pend[r] = 1'b0;
        end
        rst = 1'b0;
        clr_start = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        applyStimulus(1, 5, 32'h1234, 1, 6, 32'h5678, 1, 4, 5, 6);
        step("in_reset");
        rst = 1'b1;
        readAll("after_reset");

        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        step("wr_x5");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step("rd_x5");
        checkOutput("x5_direct", rdata[31:0], 32'hDEADBEEF);

        applyStimulus(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 0, 7);
        step("wr_x7_both");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        step("rd_x7");

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        step("sb_x9");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        step("pend_x9");
        applyStimulus(1, 9, 32'h5, 0, 0, 0, 0, 0, 9, 0);
        step("wr_x9_fwd");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        step("rd_x9");
        applyStimulus(1, 0, 32'h1, 1, 0, 32'h1, 1, 0, 0, 0);
        step("wr_x0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rd_x0");

        applyStimulus(1, 3, 32'hAB, 0, 0, 0, 1, 3, 3, 0);
        step("sb_wr_x3");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        step("rd_x3");

        fillAll();
        readAll("filled");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        step("sb_x12");
        clr_start = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 1);
        step("clr_go");
        for (int c = 0; c < NREG - 1; c++) begin
            clr_start = 1'($urandom);
            applyStimulus(1, AW'($urandom), $urandom, 1, AW'($urandom), $urandom,
                          1, AW'($urandom), AW'($urandom), AW'($urandom));
            step($sformatf("clr_busy%0d", c));
        end
        clr_start = 1'b0;
        readAll("after_clear");

        fillAll();
        clr_start = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("clr2_go");
        clr_start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, AW'(c), AW'(c + 10));
            step($sformatf("clr2_busy%0d", c));
        end
        rst = 1'b0;
        step("clr2_abort");
        rst = 1'b1;
        readAll("after_abort");
        applyStimulus(1, 17, 32'hCAFE0001, 0, 0, 0, 0, 0, 0, 0);
        step("wr_x17");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 17, 0);
        step("rd_x17");

        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] a0, a1;
            a0 = AW'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom);
            applyStimulus(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
                          1'($urandom), AW'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) == 0) ? a0 : AW'($urandom),
                          ($urandom_range(0, 1) == 0) ? a1 : AW'($urandom_range(0, 7)));
            clr_start = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 149) != 0);
            step($sformatf("rand%0d", n));
        end
        rst = 1'b1;
        clr_start = 1'b0;
        readAll("final");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
